// File: rtl/ws_sync_pkg.sv
// Shared types for the slave word-select tracker: operating mode and channel state.
package ws_sync_pkg;

  typedef enum logic [1:0] {
    I2S     = 2'd0,
    LEFT_J  = 2'd1,
    RIGHT_J = 2'd2,
    PCM     = 2'd3
  } std_t;

  typedef enum logic {
    f16bits = 1'b0,
    f32bits = 1'b1
  } fsize_t;

  typedef struct packed {
    std_t   standard;
    fsize_t frame_size;
    logic   stereo;
  } OP_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_L    = 2'd1,
    ST_R    = 2'd2
  } ws_state_t;

endpackage

// File: rtl/ws_sync.sv
// Slave-mode word-select tracker: locks to an external ws, reports channel, bit index,
// word boundaries and framing errors, all registered on the serial bit clock.
module ws_sync
  import ws_sync_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic       en,
  input  logic       ws_in,
  input  OP_t        OP,
  output ws_state_t  state,
  output logic [4:0] bit_cnt,
  output logic       word_start,
  output logic       word_end,
  output logic       frame_err
);

  logic       ws_d;
  logic       l_lvl;
  logic       idle_lvl;
  logic       ws_edge;
  logic [4:0] last;
  ws_state_t  new_ch;

  ws_state_t  state_nx;
  logic [4:0] cnt_nx;
  logic       start_nx;
  logic       end_nx;
  logic       err_nx;

  // I2S parks ws high and uses low for the left channel; the other formats invert both.
  assign l_lvl    = (OP.standard == I2S) ? 1'b0 : 1'b1;
  assign idle_lvl = ~l_lvl;
  assign ws_edge  = (ws_in != ws_d);
  assign last     = (OP.frame_size == f32bits) ? 5'd31 : 5'd15;
  assign new_ch   = (ws_in == l_lvl) ? ST_L : ST_R;

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    start_nx = 1'b0;
    end_nx   = 1'b0;
    err_nx   = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (state == ST_IDLE) begin
      if (ws_edge && (ws_in == l_lvl)) begin
        state_nx = ST_L;
        cnt_nx   = '0;
        start_nx = 1'b1;
      end
    end else if (bit_cnt > last) begin
      // Word length shrank under a word already past the new end.
      err_nx   = 1'b1;
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (ws_edge) begin
      if (!OP.stereo && (new_ch == ST_R)) begin
        err_nx   = 1'b1;
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end else begin
        // A mid-word edge is reported but the new word is still accepted.
        err_nx   = (bit_cnt != last);
        state_nx = new_ch;
        cnt_nx   = '0;
        start_nx = 1'b1;
      end
    end else if (bit_cnt == last) begin
      if (OP.stereo) begin
        err_nx   = (state == ST_L);
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end else begin
        state_nx = ST_L;
        cnt_nx   = '0;
        start_nx = 1'b1;
      end
    end else begin
      cnt_nx = bit_cnt + 5'd1;
      end_nx = (bit_cnt == (last - 5'd1));
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ws_d       <= idle_lvl;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      word_start <= 1'b0;
      word_end   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ws_d       <= ws_in;
      state      <= state_nx;
      bit_cnt    <= cnt_nx;
      word_start <= start_nx;
      word_end   <= end_nx;
      frame_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_ws_sync.sv
// Directed bench for ws_sync: lock, alternation, resync, stop, mono wrap, reset/enable.
module tb_ws_sync;
  import ws_sync_pkg::*;

  logic       clk;
  logic       rst_;
  logic       en;
  logic       ws_in;
  OP_t        op;
  ws_state_t  state;
  logic [4:0] bit_cnt;
  logic       word_start;
  logic       word_end;
  logic       frame_err;

  int total;
  int bad;

  ws_sync dut (
    .clk        (clk),
    .rst_       (rst_),
    .en         (en),
    .ws_in      (ws_in),
    .OP         (op),
    .state      (state),
    .bit_cnt    (bit_cnt),
    .word_start (word_start),
    .word_end   (word_end),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input ws_state_t st, input int cnt,
                         input bit st_p, input bit end_p, input bit err_p);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(cnt));
    chk({tag, ".word_start"}, 32'(word_start), 32'(st_p));
    chk({tag, ".word_end"}, 32'(word_end), 32'(end_p));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(err_p));
  endtask

  // Advance through bits 1..upto of a word, expecting word_end only at len-1.
  task automatic body(input string tag, input ws_state_t st, input int len, input int upto);
    for (int i = 1; i <= upto; i++) begin
      tick();
      chk_all(tag, st, i, 1'b0, (i == len - 1), 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_  = 1'b0;
    en    = 1'b1;
    ws_in = 1'b1;
    op    = '{standard: I2S, frame_size: f32bits, stereo: 1'b1};

    // Reset values
    tick();
    tick();
    chk_all("reset", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    rst_ = 1'b1;
    tick();
    chk_all("idle_no_edge", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);

    // 1. I2S f32 stereo alternation
    ws_in = 1'b0;
    tick();
    chk_all("t1_lock", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t1_L0", ST_L, 32, 31);
    ws_in = 1'b1;
    tick();
    chk_all("t1_R0s", ST_R, 0, 1'b1, 1'b0, 1'b0);
    body("t1_R0", ST_R, 32, 31);
    ws_in = 1'b0;
    tick();
    chk_all("t1_L1s", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t1_L1", ST_L, 32, 31);
    ws_in = 1'b1;
    tick();
    chk_all("t1_R1s", ST_R, 0, 1'b1, 1'b0, 1'b0);

    // 4. ws parked at idle after an R word
    body("t4_R", ST_R, 32, 31);
    tick();
    chk_all("t4_stop", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("t4_stay", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);

    // 3. early edge after 20 bits of L
    ws_in = 1'b0;
    tick();
    chk_all("t3_lock", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t3_L", ST_L, 32, 19);
    ws_in = 1'b1;
    tick();
    chk_all("t3_resync", ST_R, 0, 1'b1, 1'b0, 1'b1);
    body("t3_R", ST_R, 32, 31);
    ws_in = 1'b0;
    tick();
    chk_all("t3_locked", ST_L, 0, 1'b1, 1'b0, 1'b0);

    // 6. async reset mid-word, then enable drop
    body("t6_L", ST_L, 32, 10);
    ws_in = 1'b1;
    rst_  = 1'b0;
    #1;
    chk_all("t6_rst", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_ = 1'b1;
    tick();
    chk_all("t6_post", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    ws_in = 1'b0;
    tick();
    chk_all("t6_relock", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t6_L2", ST_L, 32, 5);
    en = 1'b0;
    tick();
    chk_all("t6_en0", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    ws_in = 1'b1;
    tick();
    ws_in = 1'b0;
    tick();
    chk_all("t6_en0_edge", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    chk_all("t6_en1_noedge", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    ws_in = 1'b1;
    tick();
    chk_all("t6_r_edge_ign", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    ws_in = 1'b0;
    tick();
    chk_all("t6_relock2", ST_L, 0, 1'b1, 1'b0, 1'b0);

    // 2. Left-justified f16 stereo: L while ws=1
    rst_  = 1'b0;
    ws_in = 1'b0;
    op    = '{standard: LEFT_J, frame_size: f16bits, stereo: 1'b1};
    tick();
    rst_ = 1'b1;
    tick();
    chk_all("t2_idle", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    ws_in = 1'b1;
    tick();
    chk_all("t2_L0s", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t2_L0", ST_L, 16, 15);
    ws_in = 1'b0;
    tick();
    chk_all("t2_R0s", ST_R, 0, 1'b1, 1'b0, 1'b0);
    body("t2_R0", ST_R, 16, 15);
    tick();
    chk_all("t2_stop", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    ws_in = 1'b1;
    tick();
    chk_all("t2_L1s", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t2_L1", ST_L, 16, 15);
    tick();
    chk_all("t2_L_stall", ST_IDLE, 0, 1'b0, 1'b0, 1'b1);

    // 5. I2S f16 mono wrap, then ws to idle level
    rst_  = 1'b0;
    ws_in = 1'b1;
    op    = '{standard: I2S, frame_size: f16bits, stereo: 1'b0};
    tick();
    rst_ = 1'b1;
    tick();
    ws_in = 1'b0;
    tick();
    chk_all("t5_w0", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t5_b0", ST_L, 16, 15);
    tick();
    chk_all("t5_w1", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t5_b1", ST_L, 16, 15);
    tick();
    chk_all("t5_w2", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("t5_b2", ST_L, 16, 15);
    ws_in = 1'b1;
    tick();
    chk_all("t5_stop", ST_IDLE, 0, 1'b0, 1'b0, 1'b1);

    // Frame size shrinks mid-word past the new end
    op    = '{standard: I2S, frame_size: f32bits, stereo: 1'b1};
    ws_in = 1'b0;
    tick();
    chk_all("fs_lock", ST_L, 0, 1'b1, 1'b0, 1'b0);
    body("fs_L", ST_L, 32, 20);
    op.frame_size = f16bits;
    tick();
    chk_all("fs_shrink", ST_IDLE, 0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
